game_state_ctrl: RTL and testbench

- Top-level game sequencer for the DDR design.
- Turns player inputs (btnR = start, btnL = quit, sw[0] = pause) and the 1 Hz tick from the clock module into the global game state.
- The `state` output drives the clock module, score and display. This block also owns the round countdown and the per-round game timer.
- Single clock domain. All asynchronous inputs are synchronised internally.

---
 rtl/game_state_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_game_state_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: global game sequencer (IDLE/COUNTDOWN/GAME/PAUSE/OVER)
// Optional button debounce is enabled by defining DEBOUNCE_EN.
module game_state_ctrl #(
   parameter int unsigned COUNTDOWN_SECS = 3,
   parameter int unsigned GAME_SECS      = 60,
   parameter logic [15:0] DEB_CYCLES     = 16'd50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btnR,
   input  logic       btnL,
   input  logic       pauseSwitch,
   input  logic       oneHz_CLK,
   output logic [2:0] output_state,
   output logic [3:0] count_left,
   output logic [7:0] time_left,
   output logic       display_combo_en,
   output logic       round_start,
   output logic       game_over
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_COUNTDOWN = 3'd1,
      S_GAME      = 3'd2,
      S_PAUSE     = 3'd3,
      S_OVER      = 3'd4
   } state_t;

   localparam logic [3:0] LP_CD_SECS   = 4'(COUNTDOWN_SECS);
   localparam logic [7:0] LP_GAME_SECS = 8'(GAME_SECS);

   // Reject out-of-range parameters at elaboration
   if (COUNTDOWN_SECS < 1 || COUNTDOWN_SECS > 15 ||
       GAME_SECS < 1 || GAME_SECS > 255 ||
       DEB_CYCLES == 16'd0) begin : g_bad_param
      $error("game_state_ctrl: parameter out of range");
   end

   // bit order: {oneHz_CLK, pauseSwitch, btnL, btnR}
   logic [3:0] w_in_raw;
   logic [3:0] r_sync1;
   logic [3:0] r_sync2;
   logic [1:0] w_btn_lvl;
   logic [2:0] w_edge_lvl;
   logic [2:0] r_hist;
   logic       w_start;
   logic       w_quit;
   logic       w_tick;
   logic       w_pause;

   state_t     r_state;
   logic [3:0] r_count;
   logic [7:0] r_time;
   logic       r_combo_en;
   logic       r_round_start;
   logic       r_game_over;

   assign w_in_raw = {oneHz_CLK, pauseSwitch, btnL, btnR};

   // Two-flop synchroniser on every asynchronous input
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_in_raw;
         r_sync2 <= r_sync1;
      end
   end

`ifdef DEBOUNCE_EN
   logic [15:0] r_deb_cnt [2];
   logic [1:0]  r_deb_lvl;

   // Buttons: debounced level follows sync level after DEB_CYCLES stable clks
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_deb_cnt[0] <= '0;
         r_deb_cnt[1] <= '0;
         r_deb_lvl    <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] != r_deb_lvl[i]) begin
               if (r_deb_cnt[i] >= DEB_CYCLES - 16'd1) begin
                  r_deb_lvl[i] <= r_sync2[i];
                  r_deb_cnt[i] <= '0;
               end else begin
                  r_deb_cnt[i] <= r_deb_cnt[i] + 16'd1;
               end
            end else begin
               r_deb_cnt[i] <= '0;
            end
         end
      end
   end

   assign w_btn_lvl = r_deb_lvl;
`else
   assign w_btn_lvl = r_sync2[1:0];
`endif

   assign w_edge_lvl = {r_sync2[3], w_btn_lvl};

   // Edge-history flops for start, quit and tick detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hist <= '0;
      end else begin
         r_hist <= w_edge_lvl;
      end
   end

   assign w_start = w_edge_lvl[0] & ~r_hist[0];
   assign w_quit  = w_edge_lvl[1] & ~r_hist[1];
   assign w_tick  = w_edge_lvl[2] & ~r_hist[2];
   assign w_pause = r_sync2[2];

   // Game FSM with registered counters, pulses and combo enable
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_count       <= '0;
         r_time        <= '0;
         r_combo_en    <= 1'b0;
         r_round_start <= 1'b0;
         r_game_over   <= 1'b0;
      end else begin
         r_round_start <= 1'b0;
         r_game_over   <= 1'b0;
         r_combo_en    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start && !w_quit && !w_pause) begin
                  r_state <= S_COUNTDOWN;
                  r_count <= LP_CD_SECS;
               end
            end
            S_COUNTDOWN: begin
               if (w_quit) begin
                  r_state <= S_IDLE;
                  r_count <= '0;
               end else if (w_tick) begin
                  if (r_count > 4'd1) begin
                     r_count <= r_count - 4'd1;
                  end else if (r_count == 4'd1) begin
                     r_state       <= S_GAME;
                     r_count       <= '0;
                     r_time        <= LP_GAME_SECS;
                     r_round_start <= 1'b1;
                     r_combo_en    <= 1'b1;
                  end
               end
            end
            S_GAME: begin
               r_combo_en <= 1'b1;
               if (w_quit) begin
                  r_state    <= S_IDLE;
                  r_time     <= '0;
                  r_combo_en <= 1'b0;
               end else if (w_pause) begin
                  r_state    <= S_PAUSE;
                  r_combo_en <= 1'b0;
               end else if (w_tick) begin
                  if (r_time > 8'd1) begin
                     r_time <= r_time - 8'd1;
                  end else if (r_time == 8'd1) begin
                     r_state     <= S_OVER;
                     r_time      <= '0;
                     r_game_over <= 1'b1;
                     r_combo_en  <= 1'b0;
                  end
               end
            end
            S_PAUSE: begin
               if (w_quit) begin
                  r_state <= S_IDLE;
                  r_time  <= '0;
               end else if (!w_pause) begin
                  r_state    <= S_GAME;
                  r_combo_en <= 1'b1;
               end
            end
            S_OVER: begin
               r_time <= '0;
               if (w_start || w_quit) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_count <= '0;
               r_time  <= '0;
            end
         endcase
      end
   end

   assign output_state     = r_state;
   assign count_left       = r_count;
   assign time_left        = r_time;
   assign display_combo_en = r_combo_en;
   assign round_start      = r_round_start;
   assign game_over        = r_game_over;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: directed table plus hand sequences for game_state_ctrl
// Default parameters (3 s countdown, 60 s round), debounce window 8 clks.
module tb_game_state_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       btnR;
   logic       btnL;
   logic       pauseSwitch;
   logic       oneHz_CLK;
   logic [2:0] output_state;
   logic [3:0] count_left;
   logic [7:0] time_left;
   logic       display_combo_en;
   logic       round_start;
   logic       game_over;

   int n_chk = 0;
   int n_err = 0;
   int rs_cnt = 0;
   int go_cnt = 0;
   logic rs_combo = 1'b0;
   logic go_combo = 1'b1;

   game_state_ctrl #(
      .COUNTDOWN_SECS(3),
      .GAME_SECS(60),
      .DEB_CYCLES(16'd8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btnR(btnR),
      .btnL(btnL),
      .pauseSwitch(pauseSwitch),
      .oneHz_CLK(oneHz_CLK),
      .output_state(output_state),
      .count_left(count_left),
      .time_left(time_left),
      .display_combo_en(display_combo_en),
      .round_start(round_start),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   // count pulse cycles and note combo enable alongside each pulse
   always @(negedge clk) begin
      if (round_start === 1'b1) begin
         rs_cnt   = rs_cnt + 1;
         rs_combo = display_combo_en;
      end
      if (game_over === 1'b1) begin
         go_cnt   = go_cnt + 1;
         go_combo = display_combo_en;
      end
   end

   typedef struct {
      logic       r;
      logic       l;
      logic       p;
      logic       t;
      logic [2:0] st;
      logic [3:0] cnt;
      logic [7:0] tl;
      logic       en;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic l, input logic p,
                      input logic t, input int st, input int cnt,
                      input int tl, input logic en);
      vec_t v;
      v.r = r; v.l = l; v.p = p; v.t = t;
      v.st = 3'(st); v.cnt = 4'(cnt); v.tl = 8'(tl); v.en = en;
      tbl.push_back(v);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic pulse_tick;
      oneHz_CLK = 1'b1;
      step(3);
      oneHz_CLK = 1'b0;
      step(3);
   endtask

   task automatic press_r;
      btnR = 1'b1;
      step(3);
      btnR = 1'b0;
      step(3);
   endtask

   task automatic to_game;
      press_r();
      repeat (3) pulse_tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      btnR = 1'b0;
      btnL = 1'b0;
      pauseSwitch = 1'b0;
      oneHz_CLK = 1'b0;
      step(2);
      chk("rst_state", 32'(output_state), 0);
      chk("rst_count", 32'(count_left), 0);
      chk("rst_time", 32'(time_left), 0);
      chk("rst_combo", 32'(display_combo_en), 0);
      chk("rst_rs", 32'(round_start), 0);
      chk("rst_go", 32'(game_over), 0);
      reset = 1'b0;
      step(2);

      //   r  l  p  t   st cnt tl  en
      add(0, 0, 0, 0,  0, 0,  0, 0);
      add(1, 0, 0, 0,  1, 3,  0, 0);
      add(0, 0, 0, 1,  1, 2,  0, 0);
      add(0, 0, 0, 0,  1, 2,  0, 0);
      add(0, 0, 0, 1,  1, 1,  0, 0);
      add(0, 0, 0, 0,  1, 1,  0, 0);
      add(0, 0, 1, 1,  2, 0, 60, 1);
      add(0, 0, 1, 0,  3, 0, 60, 0);
      add(0, 0, 1, 1,  3, 0, 60, 0);
      add(0, 0, 0, 0,  2, 0, 60, 1);
      add(0, 0, 0, 1,  2, 0, 59, 1);
      add(0, 0, 0, 0,  2, 0, 59, 1);
      add(1, 0, 0, 0,  2, 0, 59, 1);
      add(0, 0, 0, 0,  2, 0, 59, 1);
      add(0, 1, 0, 0,  0, 0,  0, 0);
      add(0, 0, 1, 0,  0, 0,  0, 0);
      add(1, 0, 1, 0,  0, 0,  0, 0);
      add(0, 0, 0, 0,  0, 0,  0, 0);
      add(1, 1, 0, 0,  0, 0,  0, 0);
      add(0, 0, 0, 0,  0, 0,  0, 0);
      add(1, 0, 0, 0,  1, 3,  0, 0);
      add(0, 0, 0, 0,  1, 3,  0, 0);
      add(1, 1, 0, 0,  0, 0,  0, 0);
      add(0, 0, 0, 0,  0, 0,  0, 0);

      foreach (tbl[i]) begin
         btnR = tbl[i].r;
         btnL = tbl[i].l;
         pauseSwitch = tbl[i].p;
         oneHz_CLK = tbl[i].t;
         step(3);
         chk($sformatf("v%0d_state", i), 32'(output_state), 32'(tbl[i].st));
         chk($sformatf("v%0d_count", i), 32'(count_left), 32'(tbl[i].cnt));
         chk($sformatf("v%0d_time", i), 32'(time_left), 32'(tbl[i].tl));
         chk($sformatf("v%0d_combo", i), 32'(display_combo_en), 32'(tbl[i].en));
      end

      // start latency: state changes exactly on the 3rd edge
      rs_cnt = 0;
      btnR = 1'b1;
      step(2);
      chk("lat_edge2", 32'(output_state), 0);
      step(1);
      chk("lat_edge3", 32'(output_state), 1);
      btnR = 1'b0;
      step(3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("cd_%0d", i), 32'(count_left), 32'(3 - i));
         pulse_tick();
      end
      chk("go_state", 32'(output_state), 2);
      chk("go_time", 32'(time_left), 60);
      chk("go_count", 32'(count_left), 0);
      chk("rs_once", 32'(rs_cnt), 1);
      chk("rs_combo", 32'(rs_combo), 1);
      chk("rs_low", 32'(round_start), 0);

      repeat (50) pulse_tick();
      chk("t10", 32'(time_left), 10);

      // pause coinciding with a tick drops the tick
      pauseSwitch = 1'b1;
      oneHz_CLK = 1'b1;
      step(3);
      chk("pz_state", 32'(output_state), 3);
      chk("pz_time", 32'(time_left), 10);
      chk("pz_combo", 32'(display_combo_en), 0);
      oneHz_CLK = 1'b0;
      step(3);
      repeat (5) pulse_tick();
      chk("pz5_state", 32'(output_state), 3);
      chk("pz5_time", 32'(time_left), 10);
      pauseSwitch = 1'b0;
      step(3);
      chk("res_state", 32'(output_state), 2);
      chk("res_time", 32'(time_left), 10);
      chk("res_combo", 32'(display_combo_en), 1);
      chk("res_no_rs", 32'(rs_cnt), 1);
      pulse_tick();
      chk("t9", 32'(time_left), 9);

      go_cnt = 0;
      repeat (8) pulse_tick();
      chk("t1", 32'(time_left), 1);
      chk("t1_state", 32'(output_state), 2);
      pulse_tick();
      chk("ov_state", 32'(output_state), 4);
      chk("ov_time", 32'(time_left), 0);
      chk("ov_combo", 32'(display_combo_en), 0);
      chk("go_once", 32'(go_cnt), 1);
      chk("go_combo", 32'(go_combo), 0);
      pulse_tick();
      chk("ov_hold", 32'(output_state), 4);
      press_r();
      chk("ov_exit", 32'(output_state), 0);

      // asynchronous reset mid-round
      to_game();
      repeat (23) pulse_tick();
      chk("pre_rst_t", 32'(time_left), 37);
      reset = 1'b1;
      #1;
      chk("arst_state", 32'(output_state), 0);
      chk("arst_time", 32'(time_left), 0);
      chk("arst_combo", 32'(display_combo_en), 0);
      step(1);
      reset = 1'b0;
      step(3);
      chk("post_rst", 32'(output_state), 0);

`ifdef DEBOUNCE_EN
      btnR = 1'b1;
      step(5);
      btnR = 1'b0;
      step(30);
      chk("deb_glitch", 32'(output_state), 0);
      btnR = 1'b1;
      step(30);
      btnR = 1'b0;
      step(30);
      chk("deb_hold", 32'(output_state), 1);
      chk("deb_count", 32'(count_left), 3);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
